// File: rtl/gol_pkg.sv
// Shared constants and the B3/S23 rule helper for the Game of Life cell.
package gol_pkg;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] BIRTH_COUNT   = 4'd3;
  localparam logic [CNT_W-1:0] SURVIVE_COUNT = 4'd2;

  function automatic logic next_state(input logic [CNT_W-1:0] cnt, input logic mid_s);
    logic res;
    case (cnt)
      BIRTH_COUNT:   res = 1'b1;
      SURVIVE_COUNT: res = mid_s;
      default:       res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/game_of_life_popcount8.sv
// Eight-input population count built as a carry-save tree of full/half adders.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module popcount8
  import gol_pkg::*;
(
  input  logic [7:0]       bits_i,
  output logic [CNT_W-1:0] sum_o
);
  logic s0, s1, s2, s4;
  logic c0, c1, c2, c3, c4, c5;

  // First rank compresses the eight weight-1 bits into three sums and three weight-2 carries.
  full_adder u_fa0 (.a(bits_i[0]), .b(bits_i[1]), .ci(bits_i[2]), .s(s0), .co(c0));
  full_adder u_fa1 (.a(bits_i[3]), .b(bits_i[4]), .ci(bits_i[5]), .s(s1), .co(c1));
  half_adder u_ha0 (.a(bits_i[6]), .b(bits_i[7]), .s(s2), .c(c2));

  full_adder u_fa2 (.a(s0), .b(s1), .ci(s2), .s(sum_o[0]), .co(c3));

  full_adder u_fa3 (.a(c0), .b(c1), .ci(c2), .s(s4), .co(c4));
  half_adder u_ha1 (.a(s4), .b(c3), .s(sum_o[1]), .c(c5));

  // The final weight-4 pair yields bits 2 and 3, so a full population of 8 reads 4'b1000.
  half_adder u_ha2 (.a(c4), .b(c5), .s(sum_o[2]), .c(sum_o[3]));
endmodule

// File: rtl/game_of_life.sv
// Single Game of Life cell: combinational B3/S23 next state plus a registered copy.
module game_of_life
  import gol_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i0,
  input  logic             i1,
  input  logic             i2,
  input  logic             i3,
  input  logic             i4,
  input  logic             i5,
  input  logic             i6,
  input  logic             i7,
  input  logic             mid,
  input  logic             en,
  output logic             alive,
  output logic             alive_q,
  output logic [CNT_W-1:0] count
);
  logic [7:0] nbr_s;
  logic       alive_d;

  assign nbr_s = {i7, i6, i5, i4, i3, i2, i1, i0};

  popcount8 u_popcount8 (.bits_i(nbr_s), .sum_o(count));

  assign alive = next_state(count, mid);

  // Generation step: load the new state only when enabled.
  always_comb begin
    alive_d = alive_q;
    if (en) begin
      alive_d = alive;
    end else begin
      alive_d = alive_q;
    end
  end

  // Cell state register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q <= 1'b0;
    end else begin
      alive_q <= alive_d;
    end
  end
endmodule

// File: tb/tb_game_of_life.sv
// Self-checking bench for game_of_life against a plain arithmetic B3/S23 model.
module tb_game_of_life;
  logic       clk;
  logic       rst_n;
  logic [7:0] nb;
  logic       mid;
  logic       en;
  logic       alive;
  logic       alive_q;
  logic [3:0] count;

  int n_checks;
  int n_fail;

  game_of_life dut (
    .clk(clk), .rst_n(rst_n),
    .i0(nb[0]), .i1(nb[1]), .i2(nb[2]), .i3(nb[3]),
    .i4(nb[4]), .i5(nb[5]), .i6(nb[6]), .i7(nb[7]),
    .mid(mid), .en(en), .alive(alive), .alive_q(alive_q), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_count(input logic [7:0] v);
    int n = 0;
    for (int k = 0; k < 8; k++) n += (v[k] === 1'b1) ? 1 : 0;
    return n;
  endfunction

  function automatic int ref_alive(input logic [7:0] v, input logic m);
    int n = ref_count(v);
    if (n == 3) return 1;
    if (n == 2) return (m === 1'b1) ? 1 : 0;
    return 0;
  endfunction

  task automatic directed(input logic [7:0] v, input logic m, input int exp_alive, input int exp_cnt);
    nb = v; mid = m; #1;
    check_eq($sformatf("dir_alive_%h_%0d", v, m), int'(alive), exp_alive);
    if (exp_cnt >= 0) check_eq($sformatf("dir_count_%h_%0d", v, m), int'(count), exp_cnt);
  endtask

  initial begin
    logic [7:0] base;
    logic [7:0] perm;
    logic [9:0] sv;
    int         ref_a;
    int         ref_c;
    int         idx [8];
    int         j;
    int         tmp;
    int         pc;

    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; nb = 8'h00; mid = 1'b0; en = 1'b0;
    #2;
    check_eq("reset_alive_q", int'(alive_q), 0);

    // Exhaustive sweep over {mid, i7..i0}.
    for (int v = 0; v < 512; v++) begin
      sv = 10'(v);
      nb = sv[7:0]; mid = sv[8];
      #1;
      ref_a = ref_alive(nb, mid);
      ref_c = ref_count(nb);
      check_eq($sformatf("sweep_alive_%0d", v), int'(alive), ref_a);
      check_eq($sformatf("sweep_count_%0d", v), int'(count), ref_c);
    end

    directed(8'h00, 1'b1, 0, 0);
    directed(8'h07, 1'b0, 1, 3);
    directed(8'h81, 1'b1, 1, 2);
    directed(8'h81, 1'b0, 0, 2);
    directed(8'hFF, 1'b1, 0, 8);
    directed(8'h0F, 1'b1, 0, 4);

    // Symmetry: shuffled neighbour bits must give identical results.
    for (int t = 0; t < 40; t++) begin
      base = 8'($urandom);
      mid  = 1'($urandom);
      for (int k = 0; k < 8; k++) idx[k] = k;
      for (int k = 7; k > 0; k--) begin
        j = int'($urandom_range(k, 0));
        tmp = idx[k]; idx[k] = idx[j]; idx[j] = tmp;
      end
      perm = 8'h00;
      for (int k = 0; k < 8; k++) perm[k] = base[idx[k]];
      pc = ref_count(base);
      nb = perm; #1;
      check_eq($sformatf("sym_count_%0d", t), int'(count), pc);
      check_eq($sformatf("sym_alive_%0d", t), int'(alive), ref_alive(base, mid));
    end

    // Reset held: clock toggles must not load the register.
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1; nb = 8'h07; mid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hold_alive_q", int'(alive_q), 0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("reg_load_birth", int'(alive_q), 1);

    @(negedge clk);
    en = 1'b0; nb = 8'h00;
    @(posedge clk); #1;
    check_eq("reg_hold_en0", int'(alive_q), 1);

    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    check_eq("reg_load_death", int'(alive_q), 0);

    @(negedge clk);
    nb = 8'h07;
    @(posedge clk); #1;
    check_eq("reg_reload", int'(alive_q), 1);

    // Asynchronous reset mid-cycle clears before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_clear", int'(alive_q), 0);
    @(posedge clk); #1;
    check_eq("async_rst_stays", int'(alive_q), 0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_load", int'(alive_q), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
